// File: rtl/cve2_mem_arbiter.sv
// cve2_mem_arbiter
//   Shares one req/gnt/rvalid memory port between the core's instruction-fetch
//   and load/store interfaces. Round-robin on contention, the selection is held
//   from the first unanswered request until it is granted, and an in-order ID
//   FIFO steers each response back to the port that issued it. All outputs are
//   combinational from inputs and state, so no cycles of latency are added.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   instr_*                   fetch side (read-only, full-word)
//   data_*                    LSU side (read/write with byte enables)
//   mem_*                     shared downstream port
//   busy_o                    at least one transaction outstanding
//
// Lock state
//   state    | meaning
//   LK_NONE  | no request pending, selection follows round-robin
//   LK_INSTR | fetch request issued but not yet granted, fetch held selected
//   LK_DATA  | LSU request issued but not yet granted, LSU held selected
module cve2_mem_arbiter #(
    parameter int MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        busy_o
);

    localparam int CntW = $clog2(MaxOutstanding + 1);
    // ID storage sized to the full index range of the counter so the write
    // index never needs truncation; only the low MaxOutstanding bits are used.
    localparam int IdsW = 1 << CntW;

    typedef enum logic [1:0] {
        LK_NONE  = 2'd0,
        LK_INSTR = 2'd1,
        LK_DATA  = 2'd2
    } lock_e;

    lock_e              r_lock;
    lock_e              w_lock_nxt;
    logic               r_last;
    logic               w_last_nxt;
    logic [CntW-1:0]    r_cnt;
    logic [CntW-1:0]    w_cnt_nxt;
    logic [CntW-1:0]    w_wr_idx;
    logic [IdsW-1:0]    r_ids;
    logic [IdsW-1:0]    w_ids_nxt;
    logic               w_full;
    logic               w_any_req;
    logic               w_sel;
    logic               w_hs;
    logic               w_pop;

    assign w_full    = (r_cnt == CntW'(MaxOutstanding));
    assign w_any_req = instr_req_i | data_req_i;
    assign mem_req_o = w_any_req & ~w_full;

    // 0 = fetch, 1 = LSU
    always_comb begin
        w_sel = 1'b0;
        if (r_lock == LK_INSTR) begin
            w_sel = 1'b0;
        end else if (r_lock == LK_DATA) begin
            w_sel = 1'b1;
        end else if (instr_req_i && !data_req_i) begin
            w_sel = 1'b0;
        end else if (data_req_i && !instr_req_i) begin
            w_sel = 1'b1;
        end else if (instr_req_i && data_req_i) begin
            w_sel = ~r_last;
        end
    end

    assign mem_we_o    = w_sel ? data_we_i    : 1'b0;
    assign mem_be_o    = w_sel ? data_be_i    : 4'hF;
    assign mem_addr_o  = w_sel ? data_addr_i  : instr_addr_i;
    assign mem_wdata_o = w_sel ? data_wdata_i : 32'h0;

    assign w_hs        = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = w_hs & ~w_sel;
    assign data_gnt_o  = w_hs & w_sel;

    // Responses with nothing outstanding are dropped rather than underflowing.
    assign w_pop          = mem_rvalid_i & (r_cnt != '0);
    assign instr_rvalid_o = w_pop & ~r_ids[0];
    assign data_rvalid_o  = w_pop & r_ids[0];
    assign instr_err_o    = mem_err_i & instr_rvalid_o;
    assign data_err_o     = mem_err_i & data_rvalid_o;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign busy_o         = (r_cnt != '0);

    always_comb begin
        w_lock_nxt = r_lock;
        if (!w_any_req) begin
            // Requester withdrew: protocol violation, but never stay stuck.
            w_lock_nxt = LK_NONE;
        end else if (mem_req_o && !mem_gnt_i) begin
            w_lock_nxt = w_sel ? LK_DATA : LK_INSTR;
        end else if (w_hs) begin
            w_lock_nxt = LK_NONE;
        end
    end

    // Head of the ID FIFO is always bit 0; a pop shifts everything down, so a
    // simultaneous push lands one slot lower than it otherwise would.
    always_comb begin
        w_wr_idx  = r_cnt - CntW'(w_pop);
        w_ids_nxt = r_ids;
        if (w_pop) begin
            w_ids_nxt = r_ids >> 1;
        end
        if (w_hs) begin
            w_ids_nxt[w_wr_idx] = w_sel;
        end
        w_cnt_nxt  = r_cnt + CntW'(w_hs) - CntW'(w_pop);
        w_last_nxt = w_hs ? w_sel : r_last;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lock <= LK_NONE;
            r_last <= 1'b1;
            r_cnt  <= '0;
            r_ids  <= '0;
        end else begin
            r_lock <= w_lock_nxt;
            r_last <= w_last_nxt;
            r_cnt  <= w_cnt_nxt;
            r_ids  <= w_ids_nxt;
        end
    end

    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(mem_rvalid_i && (r_cnt == '0)))
                else $warning("mem_rvalid_i with no transaction outstanding, response dropped");
        end
    end

endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// Self-checking bench for cve2_mem_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_cve2_mem_arbiter;

    localparam int MAXO = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    cve2_mem_arbiter #(.MaxOutstanding(MAXO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .busy_o(busy_o)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: queue of issuing ports (0 fetch, 1 LSU), last winner,
    // and the port owning an issued-but-ungranted request (-1 none).
    bit m_q[$];
    bit m_last;
    int m_owner;

    bit e_req, e_sel, e_hs, e_pop, e_head;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last  = 1'b1;
        m_owner = -1;
    endtask

    task automatic idle();
        instr_req_i  = 0; instr_addr_i = 0;
        data_req_i   = 0; data_we_i = 0; data_be_i = 0;
        data_addr_i  = 0; data_wdata_i = 0;
        mem_gnt_i    = 0; mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
    endtask

    // Called at posedge+1 after inputs are driven; compares at mid-cycle.
    task automatic settle();
        bit anyr;
        #4;
        anyr = instr_req_i | data_req_i;
        if (m_owner >= 0)                  e_sel = m_owner[0];
        else if (instr_req_i && !data_req_i) e_sel = 1'b0;
        else if (data_req_i && !instr_req_i) e_sel = 1'b1;
        else                                 e_sel = ~m_last;
        e_req  = anyr && (m_q.size() < MAXO);
        e_hs   = e_req && mem_gnt_i;
        e_pop  = mem_rvalid_i && (m_q.size() > 0);
        e_head = (m_q.size() > 0) ? m_q[0] : 1'b0;
        chk("mem_req", 32'(mem_req_o), 32'(e_req));
        if (anyr) begin
            chk("mem_we",    32'(mem_we_o),   e_sel ? 32'(data_we_i) : 32'h0);
            chk("mem_be",    32'(mem_be_o),   e_sel ? 32'(data_be_i) : 32'hF);
            chk("mem_addr",  mem_addr_o,      e_sel ? data_addr_i : instr_addr_i);
            chk("mem_wdata", mem_wdata_o,     e_sel ? data_wdata_i : 32'h0);
        end
        chk("instr_gnt",    32'(instr_gnt_o),    32'(e_hs && !e_sel));
        chk("data_gnt",     32'(data_gnt_o),     32'(e_hs && e_sel));
        chk("instr_rvalid", 32'(instr_rvalid_o), 32'(e_pop && !e_head));
        chk("data_rvalid",  32'(data_rvalid_o),  32'(e_pop && e_head));
        chk("instr_err",    32'(instr_err_o),    32'(e_pop && !e_head && mem_err_i));
        chk("data_err",     32'(data_err_o),     32'(e_pop && e_head && mem_err_i));
        chk("instr_rdata",  instr_rdata_o,       mem_rdata_i);
        chk("data_rdata",   data_rdata_o,        mem_rdata_i);
        chk("busy",         32'(busy_o),         32'(m_q.size() != 0));
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (!rst_i) begin
            if (e_pop) void'(m_q.pop_front());
            if (e_hs) begin
                m_q.push_back(e_sel);
                m_last = e_sel;
            end
            if (!(instr_req_i || data_req_i)) m_owner = -1;
            else if (e_req && !mem_gnt_i)     m_owner = int'(e_sel);
            else if (e_hs)                    m_owner = -1;
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        bit gi, gd;
        idle();
        rst_i = 1'b1;
        model_reset();
        #3;
        chk("rst_busy",   32'(busy_o),    0);
        chk("rst_req",    32'(mem_req_o), 0);
        chk("rst_gnt",    32'({instr_gnt_o, data_gnt_o}), 0);
        chk("rst_rvalid", 32'({instr_rvalid_o, data_rvalid_o}), 0);
        chk("rst_err",    32'({instr_err_o, data_err_o}), 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Single fetch, answered the next cycle.
        do_reset();
        instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
        settle();
        chk("t1_gnt",  32'(instr_gnt_o), 1);
        chk("t1_be",   32'(mem_be_o), 32'hF);
        chk("t1_addr", mem_addr_o, 32'h100);
        tick();
        instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h13;
        settle();
        chk("t1_rvalid", 32'(instr_rvalid_o), 1);
        chk("t1_rdata",  instr_rdata_o, 32'h13);
        chk("t1_busy",   32'(busy_o), 1);
        tick();
        idle();
        settle();
        chk("t1_busy_end", 32'(busy_o), 0);
        tick();

        // Continuous contention alternates I,D,I,D from reset.
        do_reset();
        instr_addr_i = 32'h1000; data_addr_i = 32'h2000;
        for (int c = 0; c < 5; c++) begin
            instr_req_i  = (c < 4);
            data_req_i   = (c < 4);
            mem_gnt_i    = 1;
            mem_rvalid_i = (c > 0);
            settle();
            if (c < 4) begin
                chk("t2_igrant", 32'(instr_gnt_o), 32'(c % 2 == 0));
                chk("t2_dgrant", 32'(data_gnt_o),  32'(c % 2 == 1));
            end
            if (c > 0) begin
                chk("t2_irvalid", 32'(instr_rvalid_o), 32'((c - 1) % 2 == 0));
                chk("t2_drvalid", 32'(data_rvalid_o),  32'((c - 1) % 2 == 1));
            end
            tick();
        end
        idle();

        // LSU write held while ungranted, fetch waiting behind it.
        do_reset();
        data_req_i = 1; data_we_i = 1; data_be_i = 4'h3;
        data_addr_i = 32'hA0; data_wdata_i = 32'hDEAD;
        for (int c = 0; c < 5; c++) begin
            if (c >= 1) begin
                instr_req_i = 1; instr_addr_i = 32'h300;
            end
            mem_gnt_i = (c >= 3);
            settle();
            if (c <= 3) begin
                chk("t3_addr", mem_addr_o, 32'hA0);
                chk("t3_we",   32'(mem_we_o), 1);
                chk("t3_be",   32'(mem_be_o), 32'h3);
            end
            chk("t3_dgnt", 32'(data_gnt_o),  32'(c == 3));
            chk("t3_ignt", 32'(instr_gnt_o), 32'(c == 4));
            tick();
            if (c == 3) begin
                data_req_i = 0; data_we_i = 0; data_be_i = 0;
            end
        end
        instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
        settle();
        chk("t3_drv", 32'(data_rvalid_o), 1);
        tick();
        settle();
        chk("t3_irv", 32'(instr_rvalid_o), 1);
        tick();
        idle();

        // Outstanding limit: two grants, then stall until the first response.
        do_reset();
        instr_req_i = 1; instr_addr_i = 32'h200; mem_gnt_i = 1;
        for (int c = 0; c < 10; c++) begin
            mem_rvalid_i = (c == 5 || c == 7 || c == 8);
            settle();
            chk("t4_req", 32'(mem_req_o), 32'(c <= 1 || c == 6));
            chk("t4_irv", 32'(instr_rvalid_o), 32'(c == 5 || c == 7 || c == 8));
            tick();
            if (c <= 1 || c == 6) instr_addr_i = instr_addr_i + 4;
            if (c == 6) instr_req_i = 0;
        end
        idle();

        // Error follows the response to its owner.
        do_reset();
        data_req_i = 1; data_addr_i = 32'h40; mem_gnt_i = 1;
        settle();
        chk("t5_dgnt", 32'(data_gnt_o), 1);
        tick();
        data_req_i = 0; instr_req_i = 1; instr_addr_i = 32'h500;
        settle();
        chk("t5_ignt", 32'(instr_gnt_o), 1);
        tick();
        instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_err_i = 1; mem_rdata_i = 32'hBAD;
        settle();
        chk("t5_drv",  32'(data_rvalid_o), 1);
        chk("t5_derr", 32'(data_err_o), 1);
        chk("t5_ierr", 32'(instr_err_o), 0);
        tick();
        mem_err_i = 0;
        settle();
        chk("t5_irv",   32'(instr_rvalid_o), 1);
        chk("t5_ierr2", 32'(instr_err_o), 0);
        tick();
        idle();

        // Reset with two outstanding, then a stray response.
        do_reset();
        instr_req_i = 1; mem_gnt_i = 1;
        settle(); tick();
        settle(); tick();
        instr_req_i = 0; mem_gnt_i = 0;
        settle();
        chk("t6_busy_pre", 32'(busy_o), 1);
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("t6_busy_rst", 32'(busy_o), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        mem_rvalid_i = 1;
        settle();
        chk("t6_irv",  32'(instr_rvalid_o), 0);
        chk("t6_drv",  32'(data_rvalid_o), 0);
        chk("t6_busy", 32'(busy_o), 0);
        tick();
        mem_rvalid_i = 0;
        settle();
        chk("t6_busy_end", 32'(busy_o), 0);
        tick();

        // Randomized traffic; requesters hold req and payload until granted.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if (!instr_req_i && $urandom_range(0, 2) == 0) begin
                instr_req_i = 1; instr_addr_i = $urandom;
            end
            if (!data_req_i && $urandom_range(0, 2) == 0) begin
                data_req_i = 1; data_we_i = 1'($urandom_range(0, 1));
                data_be_i = 4'($urandom_range(0, 15));
                data_addr_i = $urandom; data_wdata_i = $urandom;
            end
            mem_gnt_i    = ($urandom_range(0, 3) != 0);
            mem_rvalid_i = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata_i  = $urandom;
            mem_err_i    = ($urandom_range(0, 7) == 0);
            settle();
            gi = e_hs && !e_sel;
            gd = e_hs && e_sel;
            tick();
            if (gi) instr_req_i = 0;
            if (gd) data_req_i = 0;
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
